// File: rtl/eth_kv_cfg_master_if.sv
// Command handshake and register-port bundle for eth_kv_cfg_master.
// The master modport is the initiator's view; slave is the agent/responder side.
interface eth_kv_cfg_master_if #(
    parameter int unsigned REG_AWIDTH = 14
);
    // Command channel from the control agent
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [47:0]           cmd_mac;
    logic [31:0]           cmd_ip;
    logic [15:0]           cmd_udp;
    logic [15:0]           cmd_epid;
    logic                  cmd_raw_udp;

    // Register port towards the Ethernet interface
    logic                  reg_wr_req;
    logic [REG_AWIDTH-1:0] reg_wr_addr;
    logic [31:0]           reg_wr_data;
    logic                  reg_rd_req;
    logic [REG_AWIDTH-1:0] reg_rd_addr;
    logic                  reg_rd_resp;
    logic [31:0]           reg_rd_data;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_mac,
        input  cmd_ip,
        input  cmd_udp,
        input  cmd_epid,
        input  cmd_raw_udp,
        output reg_wr_req,
        output reg_wr_addr,
        output reg_wr_data,
        output reg_rd_req,
        output reg_rd_addr,
        input  reg_rd_resp,
        input  reg_rd_data
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_mac,
        output cmd_ip,
        output cmd_udp,
        output cmd_epid,
        output cmd_raw_udp,
        input  reg_wr_req,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  reg_rd_req,
        input  reg_rd_addr,
        output reg_rd_resp,
        output reg_rd_data
    );
endinterface

// File: rtl/eth_kv_cfg_master.sv
// Writes one RX key-value map entry over the register port and polls KV_CFG busy until committed.
// Optional poll limit: define ETH_KV_CFG_POLL_TIMEOUT_EN.
module eth_kv_cfg_master #(
    parameter int unsigned           REG_AWIDTH     = 14,
    parameter logic [REG_AWIDTH-1:0] ADDR_KV_MAC_LO = 14'h0040,
    parameter logic [REG_AWIDTH-1:0] ADDR_KV_MAC_HI = 14'h0044,
    parameter logic [REG_AWIDTH-1:0] ADDR_KV_IP     = 14'h0048,
    parameter logic [REG_AWIDTH-1:0] ADDR_KV_UDP    = 14'h004C,
    parameter logic [REG_AWIDTH-1:0] ADDR_KV_CFG    = 14'h0050,
    parameter int unsigned           RESP_TIMEOUT   = 16,
    parameter int unsigned           POLL_GAP       = 4,
    parameter int unsigned           MAX_POLLS      = 1024
) (
    input  logic                        bus_clk,
    input  logic                        bus_rst,
    eth_kv_cfg_master_if.master         bus,
    output logic                        done_stb,
    output logic                        done_err,
    output logic                        busy
);

    localparam logic [7:0]  RespTimeoutC = 8'(RESP_TIMEOUT);
    localparam logic [7:0]  PollGapC     = 8'(POLL_GAP);
    localparam logic [15:0] MaxPollsC    = 16'(MAX_POLLS);

    typedef enum logic [3:0] {
        StIdle,
        StWrMacLo,
        StWrMacHi,
        StWrIp,
        StWrUdp,
        StWrCfg,
        StRdReq,
        StRdWait,
        StGap,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Captured command fields
    logic [47:0] mac_q, mac_src;
    logic [31:0] ip_q, ip_src;
    logic [15:0] udp_q, udp_src;
    logic [15:0] epid_q, epid_src;
    logic        raw_q, raw_src;

    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  gap_q, gap_d;
    logic        err_d;
    logic        accept;
    logic        rd_busy;
    logic        poll_limit;

    // Registered outputs
    logic                  wr_req_q, wr_req_d;
    logic [REG_AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [REG_AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  done_stb_q, done_stb_d;
    logic                  done_err_q, done_err_d;
    logic                  busy_q, busy_d;

    logic unused_ok;

    assign bus.cmd_ready = (state_q == StIdle);
    assign accept        = bus.cmd_valid && (state_q == StIdle);
    assign rd_busy       = bus.reg_rd_data[31];

    // Only the busy flag of the CFG readback matters.
    assign unused_ok = ^{bus.reg_rd_data[30:0], MaxPollsC};

    // Accepting cycle feeds the first write straight from the inputs.
    assign mac_src  = accept ? bus.cmd_mac     : mac_q;
    assign ip_src   = accept ? bus.cmd_ip      : ip_q;
    assign udp_src  = accept ? bus.cmd_udp     : udp_q;
    assign epid_src = accept ? bus.cmd_epid    : epid_q;
    assign raw_src  = accept ? bus.cmd_raw_udp : raw_q;

`ifdef ETH_KV_CFG_POLL_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;

    always_comb begin
        poll_d = poll_q;
        if (accept) begin
            poll_d = 16'd0;
        end else if (state_q == StRdReq && poll_q != 16'hFFFF) begin
            poll_d = poll_q + 16'd1;
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            poll_q <= 16'd0;
        end else begin
            poll_q <= poll_d;
        end
    end

    assign poll_limit = (poll_q >= MaxPollsC);
`else
    assign poll_limit = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle:    if (accept) state_d = StWrMacLo;
            StWrMacLo: state_d = StWrMacHi;
            StWrMacHi: state_d = StWrIp;
            StWrIp:    state_d = StWrUdp;
            StWrUdp:   state_d = StWrCfg;
            StWrCfg:   state_d = StRdReq;
            StRdReq: begin
                state_d = StRdWait;
                tmo_d   = 8'd1;
            end
            StRdWait: begin
                // A response in the final counted cycle beats the timeout.
                if (bus.reg_rd_resp) begin
                    if (!rd_busy) begin
                        state_d = StDone;
                    end else if (poll_limit) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (POLL_GAP == 0) begin
                        state_d = StRdReq;
                    end else begin
                        state_d = StGap;
                        gap_d   = 8'd1;
                    end
                end else if (tmo_q == RespTimeoutC) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StGap: begin
                if (gap_q == PollGapC) begin
                    state_d = StRdReq;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with the state cycle.
    always_comb begin
        wr_req_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        done_stb_d = (state_d == StDone);
        done_err_d = (state_d == StDone) ? err_d : 1'b0;
        busy_d     = (state_d != StIdle);
        case (state_d)
            StWrMacLo: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ADDR_KV_MAC_LO;
                wr_data_d = mac_src[31:0];
            end
            StWrMacHi: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ADDR_KV_MAC_HI;
                wr_data_d = {16'b0, mac_src[47:32]};
            end
            StWrIp: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ADDR_KV_IP;
                wr_data_d = ip_src;
            end
            StWrUdp: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ADDR_KV_UDP;
                wr_data_d = {16'b0, udp_src};
            end
            StWrCfg: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ADDR_KV_CFG;
                wr_data_d = {15'b0, raw_src, epid_src};
            end
            StRdReq: begin
                rd_req_d  = 1'b1;
                rd_addr_d = ADDR_KV_CFG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q    <= StIdle;
            mac_q      <= 48'd0;
            ip_q       <= 32'd0;
            udp_q      <= 16'd0;
            epid_q     <= 16'd0;
            raw_q      <= 1'b0;
            tmo_q      <= 8'd0;
            gap_q      <= 8'd0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            done_stb_q <= 1'b0;
            done_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            done_stb_q <= done_stb_d;
            done_err_q <= done_err_d;
            busy_q     <= busy_d;
            if (accept) begin
                mac_q  <= bus.cmd_mac;
                ip_q   <= bus.cmd_ip;
                udp_q  <= bus.cmd_udp;
                epid_q <= bus.cmd_epid;
                raw_q  <= bus.cmd_raw_udp;
            end
        end
    end

    assign bus.reg_wr_req  = wr_req_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.reg_rd_req  = rd_req_q;
    assign bus.reg_rd_addr = rd_addr_q;
    assign done_stb        = done_stb_q;
    assign done_err        = done_err_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_eth_kv_cfg_master.sv
// Scoreboard bench for eth_kv_cfg_master: expected strobes are queued with their cycle
// when a command is driven and popped as the DUT produces them.
module tb_eth_kv_cfg_master;

    localparam int unsigned RespTimeout = 16;
    localparam int unsigned PollGap     = 4;
    localparam int unsigned MaxPolls    = 2;
    localparam int          PollStep    = 2 + PollGap;

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 done
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic bus_clk = 1'b0;
    logic bus_rst;
    logic done_stb;
    logic done_err;
    logic busy;

    eth_kv_cfg_master_if #(.REG_AWIDTH(14)) bus_if ();

    eth_kv_cfg_master #(
        .REG_AWIDTH  (14),
        .RESP_TIMEOUT(RespTimeout),
        .POLL_GAP    (PollGap),
        .MAX_POLLS   (MaxPolls)
    ) dut (
        .bus_clk (bus_clk),
        .bus_rst (bus_rst),
        .bus     (bus_if),
        .done_stb(done_stb),
        .done_err(done_err),
        .busy    (busy)
    );

    initial forever #5 bus_clk = ~bus_clk;

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;

    // Responder controls
    int  rsp_silent = 0;
    int  busy_left  = 0;
    bit  busy_stuck = 1'b0;
    int  stray_cyc  = -1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_match(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq($sformatf("sb_unexpected_kind%0d_c%0d", kind, cyc), 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("ev_kind_c%0d", cyc), 64'(kind), 64'(e.kind));
            check_eq($sformatf("ev_cycle_k%0d", kind), 64'(cyc), 64'(e.cyc));
            check_eq($sformatf("ev_addr_c%0d", cyc), 64'(addr), 64'(e.addr));
            check_eq($sformatf("ev_data_c%0d", cyc), 64'(data), 64'(e.data));
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge bus_clk) begin
        if (bus_if.reg_wr_req) sb_match(0, 32'(bus_if.reg_wr_addr), bus_if.reg_wr_data);
        if (bus_if.reg_rd_req) sb_match(1, 32'(bus_if.reg_rd_addr), 32'd0);
        if (done_stb) begin
            sb_match(2, 32'd0, 32'(done_err));
            done_cnt++;
        end
    end

    // Register responder: answers one cycle after each read request
    initial begin
        bit pend = 1'b0;
        bus_if.reg_rd_resp = 1'b0;
        bus_if.reg_rd_data = 32'd0;
        forever begin
            @(negedge bus_clk);
            bus_if.reg_rd_resp = 1'b0;
            bus_if.reg_rd_data = {1'b0, 31'($urandom)};
            if (bus_rst) begin
                pend = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                bus_if.reg_rd_resp = 1'b1;
                if (busy_stuck || busy_left > 0) begin
                    bus_if.reg_rd_data[31] = 1'b1;
                    if (busy_left > 0) busy_left--;
                end
            end else if (cyc == stray_cyc) begin
                bus_if.reg_rd_resp = 1'b1;
            end
            if (bus_if.reg_rd_req && rsp_silent == 0) pend = 1'b1;
        end
    end

    function automatic ev_t mk(input int kind, input logic [31:0] addr, input logic [31:0] data,
                               input int c);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        return e;
    endfunction

    task automatic push_writes(input int n, input int count, input logic [47:0] mac,
                               input logic [31:0] ip, input logic [15:0] udp,
                               input logic [15:0] epid, input logic raw);
        ev_t w[5];
        w[0] = mk(0, 32'h0040, mac[31:0], n + 1);
        w[1] = mk(0, 32'h0044, {16'h0, mac[47:32]}, n + 2);
        w[2] = mk(0, 32'h0048, ip, n + 3);
        w[3] = mk(0, 32'h004C, {16'h0, udp}, n + 4);
        w[4] = mk(0, 32'h0050, {15'h0, raw, epid}, n + 5);
        for (int i = 0; i < count; i++) exp_q.push_back(w[i]);
    endtask

    task automatic push_reads(input int first, input int count);
        for (int k = 0; k < count; k++) exp_q.push_back(mk(1, 32'h0050, 32'd0, first + k * PollStep));
    endtask

    task automatic push_done(input int c, input logic err);
        exp_q.push_back(mk(2, 32'd0, 32'(err), c));
    endtask

    // Waits for cmd_ready at a falling edge, raises cmd_valid, returns the accept cycle.
    task automatic start_cmd(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] udp,
                             input logic [15:0] epid, input logic raw, output int n);
        int k = 0;
        @(negedge bus_clk);
        while (!bus_if.cmd_ready && k < 100) begin
            @(negedge bus_clk);
            k++;
        end
        check_eq("cmd_ready_before_accept", 64'(bus_if.cmd_ready), 64'd1);
        bus_if.cmd_mac     = mac;
        bus_if.cmd_ip      = ip;
        bus_if.cmd_udp     = udp;
        bus_if.cmd_epid    = epid;
        bus_if.cmd_raw_udp = raw;
        bus_if.cmd_valid   = 1'b1;
        n = cyc;
    endtask

    // Drops cmd_valid and scrambles the fields; captured values must be unaffected.
    task automatic end_cmd();
        @(negedge bus_clk);
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_mac     = {16'($urandom), 32'($urandom)};
        bus_if.cmd_ip      = 32'($urandom);
        bus_if.cmd_udp     = 16'($urandom);
        bus_if.cmd_epid    = 16'($urandom);
        bus_if.cmd_raw_udp = 1'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge bus_clk);
            k++;
        end
        check_eq("done_within_budget", 64'(done_cnt >= target), 64'd1);
    endtask

    initial begin
        int n;
        int d0;
        bus_rst            = 1'b1;
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_mac     = 48'd0;
        bus_if.cmd_ip      = 32'd0;
        bus_if.cmd_udp     = 16'd0;
        bus_if.cmd_epid    = 16'd0;
        bus_if.cmd_raw_udp = 1'b0;
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        bus_rst = 1'b0;
        @(negedge bus_clk);
        check_eq("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_wr_req", 64'(bus_if.reg_wr_req), 64'd0);
        check_eq("rst_rd_req", 64'(bus_if.reg_rd_req), 64'd0);
        check_eq("rst_done", 64'({done_stb, done_err}), 64'd0);
        check_eq("rst_wr_addr", 64'(bus_if.reg_wr_addr), 64'd0);

        // Basic entry, not busy
        start_cmd(48'h00802F16C52F, 32'hC0A80A02, 16'hC001, 16'h0005, 1'b1, n);
        push_writes(n, 5, 48'h00802F16C52F, 32'hC0A80A02, 16'hC001, 16'h0005, 1'b1);
        push_reads(n + 6, 1);
        push_done(n + 8, 1'b0);
        end_cmd();
        check_eq("seq_cmd_ready_low", 64'(bus_if.cmd_ready), 64'd0);
        check_eq("seq_busy_high", 64'(busy), 64'd1);
        wait_done(1, 40);

        // Busy for three reads
        busy_left = 3;
        start_cmd(48'h123456789ABC, 32'h0A000001, 16'h1234, 16'hBEEF, 1'b0, n);
        push_writes(n, 5, 48'h123456789ABC, 32'h0A000001, 16'h1234, 16'hBEEF, 1'b0);
        push_reads(n + 6, 4);
        push_done(n + 8 + 3 * PollStep, 1'b0);
        end_cmd();
        wait_done(2, 80);

        // Responder silent: response timeout
        rsp_silent = 1;
        start_cmd(48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 1'b1, n);
        push_writes(n, 5, 48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        push_reads(n + 6, 1);
        push_done(n + 7 + RespTimeout, 1'b1);
        end_cmd();
        wait_done(3, 80);
        rsp_silent = 0;

        // Busy stuck at 1
        busy_stuck = 1'b1;
        start_cmd(48'h0000000000A5, 32'h00000001, 16'h0002, 16'h0003, 1'b0, n);
        push_writes(n, 5, 48'h0000000000A5, 32'h00000001, 16'h0002, 16'h0003, 1'b0);
`ifdef ETH_KV_CFG_POLL_TIMEOUT_EN
        push_reads(n + 6, MaxPolls);
        push_done(n + 8 + (MaxPolls - 1) * PollStep, 1'b1);
        end_cmd();
        wait_done(4, 80);
        busy_stuck = 1'b0;
`else
        push_reads(n + 6, 6);
        end_cmd();
        d0 = done_cnt;
        while (cyc < n + 40) @(negedge bus_clk);
        check_eq("stuck_no_done", 64'(done_cnt), 64'(d0));
        check_eq("stuck_still_busy", 64'(busy), 64'd1);
        check_eq("stuck_reads_consumed", 64'(exp_q.size()), 64'd0);
        bus_rst    = 1'b1;
        busy_stuck = 1'b0;
        @(negedge bus_clk);
        bus_rst = 1'b0;
        done_cnt = done_cnt + 1;
`endif

        // cmd_valid held high across a sequence, stray response during WR_IP
        start_cmd(48'h0A0B0C0D0E0F, 32'h11223344, 16'h5566, 16'h7788, 1'b1, n);
        stray_cyc = n + 3;
        push_writes(n, 5, 48'h0A0B0C0D0E0F, 32'h11223344, 16'h5566, 16'h7788, 1'b1);
        push_reads(n + 6, 1);
        push_done(n + 8, 1'b0);
        push_writes(n + 9, 5, 48'h0A0B0C0D0E0F, 32'h11223344, 16'h5566, 16'h7788, 1'b1);
        push_reads(n + 15, 1);
        push_done(n + 17, 1'b0);
        while (cyc < n + 5) @(negedge bus_clk);
        check_eq("held_cmd_ready_low", 64'(bus_if.cmd_ready), 64'd0);
        while (cyc < n + 10) @(negedge bus_clk);
        bus_if.cmd_valid = 1'b0;
        wait_done(6, 40);
        stray_cyc = -1;

        // Reset during WR_UDP
        start_cmd(48'hCAFEBABE0001, 32'hDEADBEEF, 16'h0BAD, 16'h0F00, 1'b0, n);
        push_writes(n, 3, 48'hCAFEBABE0001, 32'hDEADBEEF, 16'h0BAD, 16'h0F00, 1'b0);
        end_cmd();
        repeat (3) @(posedge bus_clk);
        #1;
        bus_rst = 1'b1;
        #1;
        check_eq("midrst_wr_req", 64'(bus_if.reg_wr_req), 64'd0);
        check_eq("midrst_rd_req", 64'(bus_if.reg_rd_req), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done_stb), 64'd0);
        repeat (2) @(negedge bus_clk);
        bus_rst = 1'b0;
        #1;
        check_eq("postrst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        check_eq("postrst_partial_writes", 64'(exp_q.size()), 64'd0);

        // Normal command after reset
        start_cmd(48'h665544332211, 32'hAC100001, 16'h2710, 16'h0042, 1'b1, n);
        push_writes(n, 5, 48'h665544332211, 32'hAC100001, 16'h2710, 16'h0042, 1'b1);
        push_reads(n + 6, 1);
        push_done(n + 8, 1'b0);
        end_cmd();
        wait_done(7, 40);

        repeat (4) @(negedge bus_clk);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
